// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: buffers host opcodes in a small FIFO and issues them to the LCD
// controller one at a time when it is not busy. Issuing the write-back opcode
// ends the sequence; done from the controller then raises seq_done until reset.
module lcd_cmd_seq #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          busy,
    input  logic          done,
    output logic [2:0]    cmd,
    output logic          cmd_valid,
    output logic [AW:0]   fifo_cnt,
    output logic [7:0]    issued_cnt,
    output logic          seq_done
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          closed;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Handshake and FIFO status, all derived from registered state only
    always_comb begin
        full       = (count == CW'(DEPTH));
        empty      = (count == '0);
        host_ready = ~full & ~closed & ~seq_done;
        push       = host_valid & host_ready;
        pop        = (state_q == S_IDLE) & ~empty & ~busy;
        fifo_cnt   = count;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; busy is only looked at in IDLE, done only in WAIT_DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop) state_d = S_ISSUE;
            S_ISSUE:     state_d = (cmd == 3'd0) ? S_WAIT_DONE : S_GAP;
            S_GAP:       state_d = S_IDLE;
            S_WAIT_DONE: if (done) state_d = S_FINISH;
            S_FINISH:    state_d = S_FINISH;
            default:     state_d = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write-back opcode closes the sequence to further host input
    always_ff @(posedge clk) begin
        if (reset) begin
            closed <= 1'b0;
        end else if (push && (host_cmd == 3'd0)) begin
            closed <= 1'b1;
        end
    end

    // Registered controller-facing outputs; the strobe is high exactly in ISSUE
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd        <= 3'd0;
            cmd_valid  <= 1'b0;
            issued_cnt <= 8'd0;
            seq_done   <= 1'b0;
        end else begin
            cmd_valid <= (state_d == S_ISSUE);
            if (pop) begin
                cmd <= mem[rd_ptr];
                if (issued_cnt != 8'hFF) begin
                    issued_cnt <= issued_cnt + 8'd1;
                end
            end
            if ((state_q == S_WAIT_DONE) && done) begin
                seq_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer placed directly upstream of the LCD controller.
- Accepts opcodes from a host or test driver over a valid/ready handshake and buffers them in a small FIFO.
- Issues them to the controller's cmd/cmd_valid pins, one at a time, only when the controller is not busy.
- After the write-back opcode is issued, it waits for the controller's done and reports sequence completion.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 3, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- host_cmd  input  3  opcode: 0 write-back, 1 up, 2 down, 3 left, 4 right, 5 average, 6 mirror-X, 7 mirror-Y.
- host_valid  input  1  host_cmd is valid this cycle.
- host_ready  output  1  the sequencer accepts host_cmd this cycle.
- busy  input  1  busy flag from the LCD controller.
- done  input  1  done flag from the LCD controller.
- cmd  output  3  opcode presented to the controller.
- cmd_valid  output  1  one-cycle issue strobe to the controller.
- fifo_cnt  output  AW+1  number of queued opcodes, 0..DEPTH.
- issued_cnt  output  8  opcodes issued since reset; saturates at 255.
- seq_done  output  1  high once done has been seen after a write-back was issued.

Behaviour:
- Reset: all of the following go to 0: state=IDLE, pointers, fifo_cnt, cmd, cmd_valid, issued_cnt, seq_done, the closed flag. Reset takes priority over every other event. Reset mid-sequence discards queued opcodes and the next cycle is IDLE.
- Push rule:
  - push = host_valid & host_ready.
  - host_ready = ~full & ~closed & ~seq_done.
  - full means fifo_cnt==DEPTH.
- Closing the sequence: pushing opcode 0 sets closed on the same edge. No further opcodes are accepted until reset, so the write-back opcode is always the last FIFO entry.
- Pop rule:
  - pop occurs on the edge that leaves IDLE for ISSUE, i.e. when state==IDLE & ~empty & ~busy.
  - The popped opcode is registered into cmd.
  - Push and pop on the same edge: fifo_cnt is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: cmd_valid=0. If ~empty and busy==0, pop and go to ISSUE. Otherwise stay in IDLE. busy=1 (for example, controller image load) holds the sequencer here.
  - ISSUE: cmd_valid=1 for exactly this one cycle, with cmd stable. issued_cnt increments, saturating at 255. If cmd==0, go to WAIT_DONE; otherwise go to GAP.
  - GAP: exactly one cycle with cmd_valid=0; cmd holds its last value. This gives the controller time to apply the operation and update busy. Go to IDLE.
  - WAIT_DONE: cmd_valid=0. When done==1, set seq_done and go to FINISH. busy is ignored in this state.
  - FINISH: terminal state. cmd_valid=0, seq_done=1, host_ready=0. Left only via reset.
- Issue rate: the minimum spacing between cmd_valid pulses is 3 cycles (ISSUE, GAP, IDLE).
- busy is sampled only in IDLE. A busy that rises during ISSUE or GAP does not abort an issued opcode.
- done seen outside WAIT_DONE is ignored.
- An empty FIFO in IDLE means the sequencer waits indefinitely with no error.
- Outputs: cmd, cmd_valid, seq_done and issued_cnt are registered. host_ready and fifo_cnt are derived from registered state, with no combinational path from host_valid.

Test Plan:
- Reset mid-stream: reset with 3 opcodes queued and the FSM in GAP -> next cycle fifo_cnt=0, cmd_valid=0, issued_cnt=0, host_ready=1.
- Busy gating: push {4,4,1} while busy=1 for 70 cycles -> no cmd_valid while busy is high. After busy falls, cmd_valid pulses carry 4, 4, 1, spaced 3 cycles apart. issued_cnt=3.
- FIFO full and wrap: hold busy=1 and push 8 opcodes -> fifo_cnt=8 and host_ready=0 on the 9th attempt. Release busy -> issue order matches push order. Then push 5 more and check that pointers wrap with order preserved.
- Simultaneous push and pop: with fifo_cnt=2 in IDLE and busy=0, push on the pop edge -> fifo_cnt stays 2 and the next issue is the older entry.
- Write-back close: push {5,6,0,7} -> 7 is refused (host_ready=0 after the 0 is accepted). Issued sequence is 5, 6, 0. FSM stays in WAIT_DONE with busy=1. Assert done for 1 cycle -> seq_done=1 on the next edge and remains 1. No cmd_valid afterwards.
- Saturation: issue 300 non-write-back opcodes -> issued_cnt=255 and it stays there.
